// File: rtl/fwd_hazard_unit_if.sv
// Operand-forwarding / hazard control bundle between the ID/EX pipeline control and fwd_hazard_unit.
// master: pipeline side, driving ID-stage fields, hold and ex_flush, and receiving the selects.
// slave: fwd_hazard_unit side, receiving the ID-stage fields and driving fwd_a/fwd_b, stall, bubble and stall_cnt.
interface fwd_hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             hold;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_wreg;
  logic             id_regwrite;
  logic             id_memread;
  logic             ex_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wreg, id_regwrite, id_memread, ex_flush,
    input  fwd_a, fwd_b, stall, bubble, stall_cnt
  );

  modport slave (
    input  hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wreg, id_regwrite, id_memread, ex_flush,
    output fwd_a, fwd_b, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for the 5-stage pipeline, with a stall counter.
// Latency: fwd_a/fwd_b/stall/bubble are combinational from the shadow EX/MEM/WB state and the ID inputs.
// Backpressure: hold=1 freezes all state; stall requests a one-cycle PC/IF-ID freeze plus ID/EX bubble.
// Ports: clk, rst_n (async active-low); bus (slave) carries ID fields, hold, ex_flush in and
//        fwd_a/fwd_b (00 regfile, 01 MEM/WB, 10 EX/MEM), stall, bubble, stall_cnt out.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fwd_hazard_unit_if.slave    bus
);

  // Shadow of the destination/source info of the instructions in EX, MEM and WB.
  logic [REG_W-1:0] ex_rs, ex_rt, ex_wreg;
  logic             ex_regwrite, ex_memread;
  logic [REG_W-1:0] mem_wreg;
  logic             mem_regwrite;
  logic [REG_W-1:0] wb_wreg;
  logic             wb_regwrite;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             mem_fwd_ok, wb_fwd_ok;
  logic             lu, stall_w, bubble_w;
  logic [1:0]       fwd_a_w, fwd_b_w;

  // A producer forwards only if it writes a real register; r0 is hardwired zero.
  assign mem_fwd_ok = mem_regwrite && (mem_wreg != '0);
  assign wb_fwd_ok  = wb_regwrite  && (wb_wreg  != '0);

  always_comb begin
    fwd_a_w = 2'b00;
    fwd_b_w = 2'b00;
    // EX/MEM is checked first so the youngest producer wins on a double match.
    if (mem_fwd_ok && (mem_wreg == ex_rs))      fwd_a_w = 2'b10;
    else if (wb_fwd_ok && (wb_wreg == ex_rs))   fwd_a_w = 2'b01;
    if (mem_fwd_ok && (mem_wreg == ex_rt))      fwd_b_w = 2'b10;
    else if (wb_fwd_ok && (wb_wreg == ex_rt))   fwd_b_w = 2'b01;
  end

  // Load in EX whose result the ID instruction needs: the value is not available until
  // the load reaches WB, so one bubble is enough to make it forwardable from MEM/WB.
  assign lu = bus.id_valid && ex_memread && ex_regwrite && (ex_wreg != '0) &&
              ((bus.id_use_rs && (bus.id_rs == ex_wreg)) ||
               (bus.id_use_rt && (bus.id_rt == ex_wreg)));

  // A taken branch squashes the dependent instruction, so no stall is needed then.
  assign stall_w  = lu && !bus.ex_flush;
  assign bubble_w = stall_w || bus.ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_wreg      <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_wreg     <= '0;
      mem_regwrite <= 1'b0;
      wb_wreg      <= '0;
      wb_regwrite  <= 1'b0;
      stall_cnt_q  <= '0;
    end else if (!bus.hold) begin
      wb_wreg      <= mem_wreg;
      wb_regwrite  <= mem_regwrite;
      mem_wreg     <= ex_wreg;
      mem_regwrite <= ex_regwrite;
      if (bubble_w) begin
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_wreg     <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end else begin
        ex_rs       <= bus.id_rs;
        ex_rt       <= bus.id_rt;
        ex_wreg     <= bus.id_wreg;
        ex_regwrite <= bus.id_valid && bus.id_regwrite;
        ex_memread  <= bus.id_valid && bus.id_memread;
      end
      if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bus.fwd_a     = fwd_a_w;
  assign bus.fwd_b     = fwd_b_w;
  assign bus.stall     = stall_w;
  assign bus.bubble    = bubble_w;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Control-side counterpart of the forwarding operand muxes in the 5-stage pipelined CPU.
- Tracks destination-register info for the instructions in EX, MEM and WB, and drives the 2-bit select codes for the two ALU-operand 3:1 muxes.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.
- Squashes the ID-stage instruction when EX resolves a taken branch.

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  global freeze (external memory wait); 1 = no internal state changes
- id_valid  input  1  ID stage holds a real instruction
- id_rs  input  REG_W  rs field of the ID instruction
- id_rt  input  REG_W  rt field of the ID instruction
- id_use_rs  input  1  ID instruction reads rs
- id_use_rt  input  1  ID instruction reads rt
- id_wreg  input  REG_W  destination register of the ID instruction (after RegDst mux)
- id_regwrite  input  1  ID instruction writes the register file
- id_memread  input  1  ID instruction is a load
- ex_flush  input  1  taken branch/jump resolved in EX this cycle
- fwd_a  output  2  rs operand select: 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result
- fwd_b  output  2  rt operand select, same encoding
- stall  output  1  freeze PC and IF/ID, insert bubble into ID/EX
- bubble  output  1  ID/EX is loaded with a NOP this cycle (stall or ex_flush)
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Internal shadow pipeline, all cleared to 0 by rst_n (asynchronous) and updated on posedge clk only when hold=0:
  - EX slot: rs, rt, wreg, regwrite, memread.
  - MEM slot: wreg, regwrite.
  - WB slot: wreg, regwrite.
- Each non-held cycle: WB <= MEM; MEM <= EX. EX <= ID fields gated by id_valid (regwrite and memread forced to 0 when id_valid=0), except when bubble=1: EX regwrite, memread, rs, rt and wreg are all loaded with 0.
- fwd_a, combinational from registered state:
  - 10 if MEM.regwrite && MEM.wreg != 0 && MEM.wreg == EX.rs;
  - else 01 if WB.regwrite && WB.wreg != 0 && WB.wreg == EX.rs;
  - else 00.
  - EX/MEM has priority over MEM/WB when both match.
  - 11 is never driven.
- fwd_b: same rules using EX.rt.
- Register 0 never forwards and never stalls.
- Load-use condition (lu), combinational: id_valid && EX.memread && EX.regwrite && EX.wreg != 0 && ((id_use_rs && id_rs == EX.wreg) || (id_use_rt && id_rt == EX.wreg)).
- stall = lu && !ex_flush. ex_flush dominates: the dependent instruction is squashed anyway.
- bubble = stall || ex_flush.
- Stall length is exactly one cycle: after the bubble, the load sits in MEM and EX holds the bubble, so lu deasserts. When the consumer reaches EX the load is in WB, so forwarding selects 01.
- hold=1:
  - all registers and stall_cnt frozen;
  - fwd_a, fwd_b, stall and bubble keep reflecting the frozen state and current inputs;
  - no advance occurs.
- stall_cnt increments by 1 on each non-held posedge where stall=1 and saturates at all-ones. Reset value is 0.
- Reset values: fwd_a=00, fwd_b=00, stall=0, bubble = ex_flush (purely combinational), stall_cnt=0.
- Reset mid-operation clears all slots at once, so no forwarding occurs from pre-reset instructions.
- Latency: selects and stall are valid in the same cycle as the registered state and ID inputs, with no added cycle.

Test Plan:
- Back-to-back ALU dependence: ID `add r3,r1,r2`, then ID `sub r4,r3,r5` (use_rs) -> in the cycle sub is in EX, fwd_a=10, fwd_b=00, stall=0.
- Distance-2 dependence with double match: add r3 (oldest), add r3, then `or r6,r3,r3` -> when or is in EX, fwd_a=fwd_b=10 (EX/MEM priority). With the middle instruction writing r7 instead -> fwd_a=fwd_b=01.
- Load-use: `lw r8` in EX, ID `add r9,r8,r1` -> stall=1 and bubble=1 for exactly one cycle, stall_cnt 0->1. Next cycle stall=0. When add is in EX, fwd_a=01.
- r0 destination: `lw r0` in EX, ID reads r0 -> stall=0. ALU write to r0 followed by a reader of r0 -> fwd_a=00.
- Flush precedence: load-use condition plus ex_flush=1 in the same cycle -> stall=0, bubble=1, stall_cnt unchanged. Next cycle the EX slot has regwrite=0, so a following reader of that register gets fwd=00.
- Hold and reset: hold=1 for 3 cycles during a load-use -> stall stays 1 and stall_cnt does not change. Assert rst_n=0 mid-stream -> fwd_a/fwd_b=00, stall=0 and stall_cnt=0 immediately, without waiting for a clock edge.
